pet_status_engine: RTL
======================

Name: pet_status_engine

Overview:
Upstream producer for the LCD 16x2 status display. Holds the pet's three statistics (food, joy, energy) and its sleep/death state, and applies time decay and user actions to them. It drives the face/food_value/joy_value/energy_value buses consumed by LCD1602_CONTROLLER. User-action inputs come from the debounced button stage as single-cycle pulses.

Parameters:
MAX_VALUE, 5, saturation ceiling of every statistic; stat width = $clog2(MAX_VALUE).
NUM_FACES, 9, face-code space (width only); must be >= 9.
TICK_MAX, 50000000, clk cycles per game tick.
DECAY_FOOD_TICKS, 3, ticks per food decrement.
DECAY_JOY_TICKS, 4, ticks per joy decrement.
DECAY_ENERGY_TICKS, 5, ticks per energy decrement (awake only).
FACE_HOLD_TICKS, 2, ticks the eating/playing face is held.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_feed  in  1  one-cycle pulse, feed request
btn_play  in  1  one-cycle pulse, play request
btn_sleep  in  1  one-cycle pulse, sleep/wake toggle
face  out  $clog2(NUM_FACES)  face code, registered
food_value  out  $clog2(MAX_VALUE)  0..MAX_VALUE, registered
joy_value  out  $clog2(MAX_VALUE)  0..MAX_VALUE, registered
energy_value  out  $clog2(MAX_VALUE)  0..MAX_VALUE, registered
sleeping  out  1  high in SLEEP state
dead  out  1  high in DEAD state
status_changed  out  1  one-cycle pulse when any of face/food/joy/energy changed in the previous cycle

Behaviour:
- One clock (clk); reset is synchronous, active-high. It is sampled on every edge and overrides everything else, including mid-sleep and mid-hold.
- Reset state: food = joy = energy = MAX_VALUE; face = 0; sleeping = 0; dead = 0; status_changed = 0; state = AWAKE; all counters = 0.
- Tick generator: tick_cnt counts 0..TICK_MAX-1. tick is a one-cycle pulse in the cycle tick_cnt == TICK_MAX-1, then tick_cnt wraps to 0. It runs in every state.
- Per-stat decay counters count ticks. When a counter reaches DECAY_x-1 on a tick, the stat decrements (floor 0) and the counter wraps to 0. A paused counter holds its value.
- FSM states:
  - AWAKE:
    - All three decay counters run.
    - btn_sleep -> SLEEP.
    - food==0 && energy==0 -> DEAD (checked on the registered stats).
  - SLEEP:
    - Food decay runs. Joy counter paused. Energy counter paused, and energy +1 per tick (saturating).
    - btn_feed and btn_play are ignored.
    - btn_sleep -> AWAKE.
    - energy == MAX_VALUE after the increment -> AWAKE (auto-wake).
  - DEAD: all stats frozen, all buttons ignored; only reset exits.
- Button arbitration: if several buttons pulse in one cycle, priority is sleep > feed > play; the others are dropped.
- Feed (AWAKE): food = min(food+2, MAX_VALUE); hold counter loaded with FACE_HOLD_TICKS, hold type = EAT.
- Play (AWAKE):
  - Only if energy > 0: joy = min(joy+2, MAX_VALUE), energy -= 1; hold counter loaded, hold type = PLAY.
  - Ignored if energy == 0.
- Button coincident with a decay step on the same stat: result = sat(stat - decay + bonus) in one update, clamped to 0..MAX_VALUE. Intermediate width must not wrap.
- Hold counter decrements on each tick while nonzero. A new feed/play reloads it and replaces the hold type. It is cleared on entry to SLEEP or DEAD.
- Face codes, first match wins:
  - 8 DEAD
  - 5 SLEEP
  - 6 eating hold
  - 7 playing hold
  - 2 food <= 1
  - 4 energy <= 1
  - 3 joy <= 1
  - 0 all stats >= MAX_VALUE-1
  - 1 otherwise
- face is registered from the registered stats/state, so it lags a stat change by 1 cycle.
- status_changed asserts in the cycle after any output bus differs from its previous value (compare against delayed copies). It never asserts in the cycle reset is high, nor the cycle after reset.

Test Plan:
Params for all tests: TICK_MAX=4, DECAY_FOOD_TICKS=2, DECAY_JOY_TICKS=3, DECAY_ENERGY_TICKS=4, FACE_HOLD_TICKS=2.
1. Release reset, no buttons, 12 cycles -> food=4 after tick 2, joy=4 after tick 3, energy=5; face=0 throughout; status_changed pulses once per stat change.
2. Pulse btn_feed at food=5 -> food stays 5; face=6 one cycle later, back to 0 after 2 ticks.
3. Force energy=0 by idling, then pulse btn_play -> no change. At energy=3, joy=2: btn_play -> joy=4, energy=2, face=7.
4. btn_sleep at energy=2 -> sleeping=1, face=5; energy 3,4,5 on the next three ticks, then auto-wake; joy unchanged while asleep.
5. No input from reset -> food=0 at tick 10, joy=0 at tick 15, energy=0 at tick 20; dead=1, face=8; buttons ignored; reset pulse restores 5/5/5, face=0.
6. btn_feed and btn_play in the same cycle -> only the feed is applied. Reset asserted mid-SLEEP -> AWAKE with all stats 5 on the next edge.

Source files
------------

// File: rtl/pet_status_engine.sv
// Pet statistics engine: tick-based decay, feed/play/sleep actions, face selection
// and change notification for the LCD status display.
module pet_status_engine #(
  parameter int unsigned MAX_VALUE          = 5,
  parameter int unsigned NUM_FACES          = 9,
  parameter int unsigned TICK_MAX           = 50000000,
  parameter int unsigned DECAY_FOOD_TICKS   = 3,
  parameter int unsigned DECAY_JOY_TICKS    = 4,
  parameter int unsigned DECAY_ENERGY_TICKS = 5,
  parameter int unsigned FACE_HOLD_TICKS    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           btn_feed,
  input  logic                           btn_play,
  input  logic                           btn_sleep,
  output logic [$clog2(NUM_FACES)-1:0]   face,
  output logic [$clog2(MAX_VALUE)-1:0]   food_value,
  output logic [$clog2(MAX_VALUE)-1:0]   joy_value,
  output logic [$clog2(MAX_VALUE)-1:0]   energy_value,
  output logic                           sleeping,
  output logic                           dead,
  output logic                           status_changed
);

  localparam int unsigned SW   = $clog2(MAX_VALUE);
  localparam int unsigned WW   = SW + 2;
  localparam int unsigned FW   = $clog2(NUM_FACES);
  localparam int unsigned TW   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int unsigned DMAX = (DECAY_FOOD_TICKS > DECAY_JOY_TICKS) ?
                                 ((DECAY_FOOD_TICKS > DECAY_ENERGY_TICKS) ? DECAY_FOOD_TICKS : DECAY_ENERGY_TICKS) :
                                 ((DECAY_JOY_TICKS > DECAY_ENERGY_TICKS) ? DECAY_JOY_TICKS : DECAY_ENERGY_TICKS);
  localparam int unsigned CW   = $clog2(DMAX + 1);
  localparam int unsigned HW   = $clog2(FACE_HOLD_TICKS + 1);

  localparam logic [1:0] ST_AWAKE = 2'd0;
  localparam logic [1:0] ST_SLEEP = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  logic [1:0]    state, state_n;
  logic [TW-1:0] tick_cnt;
  logic          tick_c;
  logic [CW-1:0] food_cnt, joy_cnt, energy_cnt, food_cnt_n, joy_cnt_n, energy_cnt_n;
  logic [CW:0]   food_step, joy_step, energy_step;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          hold_eat, hold_eat_n;
  logic [SW-1:0] food_n, joy_n, energy_n;
  logic [1:0]    food_sub, joy_sub, energy_sub, food_add, joy_add, energy_add;
  logic [FW-1:0] face_n, face_q;
  logic [SW-1:0] food_q, joy_q, energy_q;
  logic          changed_c;

  // Advance a decay counter by one tick; MSB flags the wrap (a decrement is due).
  function automatic logic [CW:0] step_cnt(input logic [CW-1:0] c, input int unsigned lim);
    if (c == CW'(lim - 1)) return {1'b1, {CW{1'b0}}};
    return {1'b0, c + CW'(1)};
  endfunction

  // Combined add/subtract in a wider domain, clamped to 0..MAX_VALUE.
  function automatic logic [SW-1:0] sat_update(input logic [SW-1:0] v, input logic [1:0] sub,
                                               input logic [1:0] add);
    logic [WW-1:0] s;
    s = WW'(v) + WW'(add);
    s = (s > WW'(sub)) ? s - WW'(sub) : '0;
    if (s > WW'(MAX_VALUE)) s = WW'(MAX_VALUE);
    return s[SW-1:0];
  endfunction

  assign tick_c      = (tick_cnt == TW'(TICK_MAX - 1));
  assign food_step   = step_cnt(food_cnt, DECAY_FOOD_TICKS);
  assign joy_step    = step_cnt(joy_cnt, DECAY_JOY_TICKS);
  assign energy_step = step_cnt(energy_cnt, DECAY_ENERGY_TICKS);
  assign changed_c   = (face != face_q) || (food_value != food_q) ||
                       (joy_value != joy_q) || (energy_value != energy_q);

  // Next-state, stat update and face selection.
  always_comb begin
    state_n      = state;
    food_cnt_n   = food_cnt;
    joy_cnt_n    = joy_cnt;
    energy_cnt_n = energy_cnt;
    hold_n       = hold_cnt;
    hold_eat_n   = hold_eat;
    food_sub     = 2'd0;
    joy_sub      = 2'd0;
    energy_sub   = 2'd0;
    food_add     = 2'd0;
    joy_add      = 2'd0;
    energy_add   = 2'd0;
    face_n       = FW'(1);

    if (tick_c && (hold_cnt != '0)) hold_n = hold_cnt - HW'(1);

    case (state)
      ST_AWAKE: begin
        if ((food_value == '0) && (energy_value == '0)) begin
          state_n = ST_DEAD;
          hold_n  = '0;
        end else begin
          if (tick_c) begin
            food_cnt_n   = food_step[CW-1:0];
            joy_cnt_n    = joy_step[CW-1:0];
            energy_cnt_n = energy_step[CW-1:0];
            food_sub     = {1'b0, food_step[CW]};
            joy_sub      = {1'b0, joy_step[CW]};
            energy_sub   = {1'b0, energy_step[CW]};
          end
          if (btn_sleep) begin
            state_n = ST_SLEEP;
            hold_n  = '0;
          end else if (btn_feed) begin
            food_add   = 2'd2;
            hold_n     = HW'(FACE_HOLD_TICKS);
            hold_eat_n = 1'b1;
          end else if (btn_play && (energy_value != '0)) begin
            joy_add    = 2'd2;
            energy_sub = energy_sub + 2'd1;
            hold_n     = HW'(FACE_HOLD_TICKS);
            hold_eat_n = 1'b0;
          end
        end
      end
      ST_SLEEP: begin
        if (tick_c) begin
          food_cnt_n = food_step[CW-1:0];
          food_sub   = {1'b0, food_step[CW]};
          energy_add = 2'd1;
        end
        if (btn_sleep) state_n = ST_AWAKE;
      end
      default: ;
    endcase

    food_n   = sat_update(food_value, food_sub, food_add);
    joy_n    = sat_update(joy_value, joy_sub, joy_add);
    energy_n = sat_update(energy_value, energy_sub, energy_add);

    // Auto-wake once a sleeping tick tops energy up to the ceiling.
    if ((state == ST_SLEEP) && !btn_sleep && tick_c && (energy_n == SW'(MAX_VALUE)))
      state_n = ST_AWAKE;

    if (state == ST_DEAD)                                face_n = FW'(8);
    else if (state == ST_SLEEP)                          face_n = FW'(5);
    else if ((hold_cnt != '0) && hold_eat)               face_n = FW'(6);
    else if (hold_cnt != '0)                             face_n = FW'(7);
    else if (food_value <= SW'(1))                       face_n = FW'(2);
    else if (energy_value <= SW'(1))                     face_n = FW'(4);
    else if (joy_value <= SW'(1))                        face_n = FW'(3);
    else if ((food_value >= SW'(MAX_VALUE - 1)) && (joy_value >= SW'(MAX_VALUE - 1)) &&
             (energy_value >= SW'(MAX_VALUE - 1)))       face_n = FW'(0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_AWAKE;
      tick_cnt       <= '0;
      food_cnt       <= '0;
      joy_cnt        <= '0;
      energy_cnt     <= '0;
      hold_cnt       <= '0;
      hold_eat       <= 1'b0;
      food_value     <= SW'(MAX_VALUE);
      joy_value      <= SW'(MAX_VALUE);
      energy_value   <= SW'(MAX_VALUE);
      face           <= '0;
      sleeping       <= 1'b0;
      dead           <= 1'b0;
      status_changed <= 1'b0;
      face_q         <= '0;
      food_q         <= SW'(MAX_VALUE);
      joy_q          <= SW'(MAX_VALUE);
      energy_q       <= SW'(MAX_VALUE);
    end else begin
      state          <= state_n;
      tick_cnt       <= tick_c ? '0 : tick_cnt + TW'(1);
      food_cnt       <= food_cnt_n;
      joy_cnt        <= joy_cnt_n;
      energy_cnt     <= energy_cnt_n;
      hold_cnt       <= hold_n;
      hold_eat       <= hold_eat_n;
      food_value     <= food_n;
      joy_value      <= joy_n;
      energy_value   <= energy_n;
      face           <= face_n;
      sleeping       <= (state_n == ST_SLEEP);
      dead           <= (state_n == ST_DEAD);
      status_changed <= changed_c;
      face_q         <= face;
      food_q         <= food_value;
      joy_q          <= joy_value;
      energy_q       <= energy_value;
    end
  end

endmodule
